// File: rtl/block_sync_66b.sv
// 64B/66B receive block synchronizer with hunt/slip/wait/lock FSM.
// Define BLOCK_SYNC_DESCRAMBLER_EN to include the 1+x^39+x^58 descrambler.
`timescale 1ns/1ps
module block_sync_66b #(
  parameter int LOCK_COUNT = 64,
  parameter int BAD_LIMIT  = 16,
  parameter int SLIP_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din_valid,
  input  logic [65:0] din_66b,
  output logic        slip,
  output logic        block_lock,
  output logic        dout_valid,
  output logic [65:0] dout_66b,
  output logic        hdr_err,
  output logic [15:0] err_count
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SLIP   = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam int SHW = $clog2(LOCK_COUNT + 1);
  localparam int BDW = $clog2(BAD_LIMIT + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  localparam logic [SHW-1:0] SH_LAST = SHW'(LOCK_COUNT - 1);
  localparam logic [BDW-1:0] BD_LAST = BDW'(BAD_LIMIT - 1);
  localparam logic [WTW-1:0] WT_LAST = WTW'(SLIP_WAIT - 1);

  logic [1:0]     state;
  logic [SHW-1:0] sh_cnt;
  logic [BDW-1:0] bad_cnt;
  logic [WTW-1:0] wait_cnt;
  logic           slip_r;
  logic           lock_r;
  logic           dv_r;
  logic           he_r;
  logic [65:0]    dout_r;
  logic [15:0]    err_r;

  logic           acc;
  logic           hdr_ok;
  logic [63:0]    plain;

  assign acc    = en & din_valid;
  assign hdr_ok = din_66b[65] ^ din_66b[64];

`ifdef BLOCK_SYNC_DESCRAMBLER_EN
  logic [57:0] scr_q;
  logic [57:0] scr_n;

  // Serial descrambler unrolled over the 64 payload bits, LSB first
  always_comb begin
    scr_n = scr_q;
    plain = '0;
    for (int i = 0; i < 64; i++) begin
      plain[i] = din_66b[i] ^ scr_n[38] ^ scr_n[57];
      scr_n    = {scr_n[56:0], din_66b[i]};
    end
  end

  // State follows received bits only while hunting or locked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr_q <= '0;
    end else if (acc && (state == HUNT || state == LOCKED)) begin
      scr_q <= scr_n;
    end
  end
`else
  assign plain = din_66b[63:0];
`endif

  // Lock FSM, window counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      sh_cnt   <= '0;
      bad_cnt  <= '0;
      wait_cnt <= '0;
      slip_r   <= 1'b0;
      lock_r   <= 1'b0;
      dv_r     <= 1'b0;
      he_r     <= 1'b0;
      dout_r   <= '0;
      err_r    <= '0;
    end else if (en) begin
      dv_r <= 1'b0;
      he_r <= 1'b0;
      unique case (state)
        HUNT: begin
          if (acc) begin
            if (!hdr_ok) begin
              he_r   <= 1'b1;
              sh_cnt <= '0;
              slip_r <= 1'b1;
              state  <= SLIP;
            end else if (sh_cnt == SH_LAST) begin
              sh_cnt  <= '0;
              bad_cnt <= '0;
              lock_r  <= 1'b1;
              state   <= LOCKED;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
        end
        SLIP: begin
          slip_r   <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WT_LAST) begin
            wait_cnt <= '0;
            sh_cnt   <= '0;
            bad_cnt  <= '0;
            state    <= HUNT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (acc) begin
            if (!hdr_ok) begin
              he_r <= 1'b1;
              if (err_r != 16'hFFFF) err_r <= err_r + 1'b1;
            end
            if (!hdr_ok && bad_cnt == BD_LAST) begin
              lock_r  <= 1'b0;
              slip_r  <= 1'b1;
              sh_cnt  <= '0;
              bad_cnt <= '0;
              state   <= SLIP;
            end else begin
              dv_r   <= 1'b1;
              dout_r <= {din_66b[65:64], plain};
              if (sh_cnt == SH_LAST) begin
                sh_cnt  <= '0;
                bad_cnt <= '0;
              end else begin
                sh_cnt <= sh_cnt + 1'b1;
                if (!hdr_ok) bad_cnt <= bad_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end else begin
      dv_r <= 1'b0;
      he_r <= 1'b0;
    end
  end

  // A disabled stage presents no pulses; a pending slip is held until re-enabled
  assign slip       = slip_r & en;
  assign dout_valid = dv_r & en;
  assign hdr_err    = he_r & en;
  assign block_lock = lock_r;
  assign dout_66b   = dout_r;
  assign err_count  = err_r;

endmodule

// File: tb/tb_block_sync_66b.sv
// Directed testbench for block_sync_66b.
// Payload checks follow BLOCK_SYNC_DESCRAMBLER_EN when it is defined.
`timescale 1ns/1ps
module tb_block_sync_66b;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        din_valid;
  logic [65:0] din_66b;
  logic        slip;
  logic        block_lock;
  logic        dout_valid;
  logic [65:0] dout_66b;
  logic        hdr_err;
  logic [15:0] err_count;

  int          errors = 0;
  int          checks = 0;
  int          n;
  logic [57:0] tx_s;
  logic [63:0] scr;
  logic [63:0] pt [5];

  always #5 clk = ~clk;

  block_sync_66b dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din_valid  (din_valid),
    .din_66b    (din_66b),
    .slip       (slip),
    .block_lock (block_lock),
    .dout_valid (dout_valid),
    .dout_66b   (dout_66b),
    .hdr_err    (hdr_err),
    .err_count  (err_count)
  );

  task automatic chk(input string tag, input logic [65:0] got,
                     input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] h, input logic [63:0] p);
    en        = 1'b1;
    din_valid = 1'b1;
    din_66b   = {h, p};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b1;
  endtask

  // Transmit-side scrambler: the scrambled bit is fed back
  task automatic scramble(input logic [63:0] d, output logic [63:0] o);
    logic b;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      b    = d[i] ^ tx_s[38] ^ tx_s[57];
      o[i] = b;
      tx_s = {tx_s[56:0], b};
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    din_valid = 1'b0;
    din_66b   = '0;
    tx_s      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", 66'(block_lock), 66'd0);
    chk("rst_slip", 66'(slip), 66'd0);
    chk("rst_dv", 66'(dout_valid), 66'd0);
    chk("rst_herr", 66'(hdr_err), 66'd0);
    chk("rst_dout", dout_66b, 66'd0);
    chk("rst_err", 66'(err_count), 66'd0);
    rst = 1'b1;

    // Lock acquisition
    for (int i = 1; i <= 63; i++) send(2'b01, 64'(i));
    chk("lock_early", 66'(block_lock), 66'd0);
    send(2'b01, 64'd64);
    chk("lock_rise", 66'(block_lock), 66'd1);
    chk("dv_at_lock", 66'(dout_valid), 66'd0);
    send(2'b01, 64'hA5A5);
    chk("dv_first", 66'(dout_valid), 66'd1);
    chk("dout_hdr", 66'(dout_66b[65:64]), 66'd1);
`ifndef BLOCK_SYNC_DESCRAMBLER_EN
    chk("dout_pass", dout_66b, {2'b01, 64'hA5A5});
`endif

    // Tolerance: 15 bad headers at window positions 2..16
    n = 0;
    for (int p = 2; p <= 64; p++) begin
      if (p <= 16) begin
        send(2'b00, 64'(p));
        if (dout_valid) n++;
        if (p == 2) begin
          chk("tol_herr", 66'(hdr_err), 66'd1);
          chk("tol_fwd_hdr", 66'(dout_66b[65:64]), 66'd0);
        end
      end else begin
        send(2'b10, 64'(p));
      end
    end
    chk("tol_lock", 66'(block_lock), 66'd1);
    chk("tol_err", 66'(err_count), 66'd15);
    chk("tol_fwd", 66'(n), 66'd15);

    // Loss of lock: bad headers at positions 49..64 of the next window
    for (int p = 1; p <= 63; p++) send((p >= 49) ? 2'b00 : 2'b01, 64'(p));
    chk("loss_pre_lock", 66'(block_lock), 66'd1);
    chk("loss_pre_err", 66'(err_count), 66'd30);
    chk("loss_pre_dv", 66'(dout_valid), 66'd1);
    send(2'b00, 64'd64);
    chk("loss_lock", 66'(block_lock), 66'd0);
    chk("loss_slip", 66'(slip), 66'd1);
    chk("loss_dv", 66'(dout_valid), 66'd0);
    chk("loss_herr", 66'(hdr_err), 66'd1);
    chk("loss_err", 66'(err_count), 66'd31);
    send(2'b01, 64'd0);
    chk("loss_slip_len", 66'(slip), 66'd0);

    // Asynchronous reset while in WAIT
    send(2'b01, 64'd0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_err", 66'(err_count), 66'd0);
    chk("arst_dout", dout_66b, 66'd0);
    chk("arst_lock", 66'(block_lock), 66'd0);
    chk("arst_slip", 66'(slip), 66'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 63; i++) send(2'b10, 64'(i));
    chk("arst_hunt_early", 66'(block_lock), 66'd0);
    send(2'b10, 64'd64);
    chk("arst_hunt_lock", 66'(block_lock), 66'd1);

    // Hunt failure on block 10
    do_reset();
    for (int i = 1; i <= 9; i++) send(2'b01, 64'(i));
    send(2'b11, 64'd10);
    chk("hunt_herr", 66'(hdr_err), 66'd1);
    chk("hunt_slip", 66'(slip), 66'd1);
    send(2'b01, 64'd0);
    chk("hunt_slip_len", 66'(slip), 66'd0);
    chk("hunt_herr_len", 66'(hdr_err), 66'd0);
    for (int i = 2; i <= 68; i++) send(2'b01, 64'(i));
    chk("hunt_relock_early", 66'(block_lock), 66'd0);
    send(2'b01, 64'd69);
    chk("hunt_relock", 66'(block_lock), 66'd1);

    // Enable low for 5 cycles while locked, with bad headers offered
    for (int i = 1; i <= 48; i++) send(2'b01, 64'(i));
    en        = 1'b0;
    din_valid = 1'b1;
    din_66b   = {2'b00, 64'd0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("en_dv", 66'(dout_valid), 66'd0);
      chk("en_herr", 66'(hdr_err), 66'd0);
    end
    chk("en_err_frozen", 66'(err_count), 66'd0);
    for (int p = 49; p <= 63; p++) send(2'b00, 64'(p));
    chk("en_lock_hold", 66'(block_lock), 66'd1);
    chk("en_err", 66'(err_count), 66'd15);
    send(2'b00, 64'd64);
    chk("en_loss", 66'(block_lock), 66'd0);
    chk("en_loss_err", 66'(err_count), 66'd16);

    // Descrambler payload path
    do_reset();
    tx_s = '0;
    for (int i = 1; i <= 64; i++) send(2'b01, 64'd0);
    chk("dsc_lock", 66'(block_lock), 66'd1);
    pt[0] = 64'd0;
    pt[1] = 64'hDEADBEEF_01234567;
    pt[2] = 64'd0;
    pt[3] = 64'hDEADBEEF_01234567;
    pt[4] = 64'hFFFF_0000_1234_ABCD;
    for (int k = 0; k < 5; k++) begin
      scramble(pt[k], scr);
      send(2'b10, scr);
      if (k >= 1) begin
        chk("dsc_dv", 66'(dout_valid), 66'd1);
`ifdef BLOCK_SYNC_DESCRAMBLER_EN
        chk("dsc_payload", dout_66b, {2'b10, pt[k]});
`else
        chk("dsc_pass", dout_66b, {2'b10, scr});
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
